// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - shared register map, status bit indices and FSM state type
//
// Register offsets are word indices decoded on busAddress[3:2].
// STATUS bit indices locate each flag inside the STATUS read word.
package uart_tx_mmio_pkg;

  localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
  localparam logic [1:0] UART_REG_STATUS  = 2'd1;
  localparam logic [1:0] UART_REG_DIVISOR = 2'd2;

  localparam int UART_ST_FULL  = 0;
  localparam int UART_ST_EMPTY = 1;
  localparam int UART_ST_BUSY  = 2;
  localparam int UART_ST_OVF   = 3;
  localparam int UART_ST_COUNT = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // A divisor of zero would stall the baud counter, so it is stored as one.
  function automatic logic [15:0] clamp_divisor(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// rtl/uart_tx_mmio_sync_fifo.sv - synchronous FIFO buffering bytes for the transmitter
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset (clears pointers)
//   push, wdata  write request and data; ignored while full
//   pop, rdata   read request; rdata shows the head entry combinationally
//   full, empty  occupancy flags
//   count        number of stored entries (0..2**AW)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // A push against a full FIFO is dropped even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO
//
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   busAddress      byte address from the core
//   busWriteData    store data, lane-aligned
//   busWriteEnable  store strobe
//   busReadData     combinational register read data, 0 when not selected
//   busSelect       address falls inside the 16-byte register window
//   txd             serial output, idle high
//   txIrq           FIFO empty and transmitter idle
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          CLK_DIV   = 434,
  parameter int          FIFO_AW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] busAddress,
  input  logic [31:0] busWriteData,
  input  logic        busWriteEnable,
  output logic [31:0] busReadData,
  output logic        busSelect,
  output logic        txd,
  output logic        txIrq
);

  logic [1:0]       reg_sel;
  logic             wr_en;
  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  logic             overflow;
  logic [15:0]      divisor;

  tx_state_t        state;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt;
  logic [15:0]      baud_cnt;
  logic             baud_done;

  logic             unused_bus;

  assign reg_sel    = busAddress[3:2];
  assign busSelect  = (busAddress[31:4] == BASE_ADDR[31:4]);
  assign wr_en      = busWriteEnable && busSelect;
  assign fifo_push  = wr_en && (reg_sel == UART_REG_TXDATA);
  assign baud_done  = (baud_cnt == 16'd0);
  assign unused_bus = ^{busWriteData[31:16], busAddress[1:0]};

  // Pops line up with the FSM loading a new frame: from IDLE, or straight
  // out of a finished stop bit so back-to-back frames have no idle gap.
  assign fifo_pop = !fifo_empty &&
                    ((state == TX_IDLE) || ((state == TX_STOP) && baud_done));

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (busWriteData[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      divisor  <= clamp_divisor(16'(CLK_DIV));
    end else begin
      if (fifo_push && fifo_full) begin
        overflow <= 1'b1;
      end else if (wr_en && (reg_sel == UART_REG_STATUS) && busWriteData[UART_ST_OVF]) begin
        overflow <= 1'b0;
      end
      if (wr_en && (reg_sel == UART_REG_DIVISOR)) begin
        divisor <= clamp_divisor(busWriteData[15:0]);
      end
    end
  end

  // Every bit reloads baud_cnt from the live divisor, so a divisor change
  // lands on the next bit boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= TX_IDLE;
      txd       <= 1'b1;
      shift_reg <= 8'd0;
      bit_cnt   <= 3'd0;
      baud_cnt  <= 16'd0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            shift_reg <= fifo_rdata;
            txd       <= 1'b0;
            baud_cnt  <= divisor - 16'd1;
            state     <= TX_START;
          end
        end
        TX_START: begin
          if (baud_done) begin
            txd      <= shift_reg[0];
            bit_cnt  <= 3'd0;
            baud_cnt <= divisor - 16'd1;
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt <= divisor - 16'd1;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= TX_STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              txd       <= shift_reg[1];
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            if (!fifo_empty) begin
              shift_reg <= fifo_rdata;
              txd       <= 1'b0;
              baud_cnt  <= divisor - 16'd1;
              state     <= TX_START;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= TX_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  assign txIrq = fifo_empty && (state == TX_IDLE);

  // Combinational read: the core samples read data in the same cycle it drives the address.
  always_comb begin
    busReadData = 32'd0;
    if (busSelect) begin
      case (reg_sel)
        UART_REG_STATUS: begin
          busReadData[UART_ST_FULL]                 = fifo_full;
          busReadData[UART_ST_EMPTY]                = fifo_empty;
          busReadData[UART_ST_BUSY]                 = (state != TX_IDLE);
          busReadData[UART_ST_OVF]                  = overflow;
          busReadData[UART_ST_COUNT +: FIFO_AW + 1] = fifo_count;
        end
        UART_REG_DIVISOR: busReadData[15:0] = divisor;
        default:          busReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio with a frame-level reference model
module tb_uart_tx_mmio;

  localparam logic [31:0] A_TX  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = 32'h8000_0004;
  localparam logic [31:0] A_DIV = 32'h8000_0008;
  localparam logic [31:0] A_RSV = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] busAddress;
  logic [31:0] busWriteData;
  logic        busWriteEnable;
  logic [31:0] busReadData;
  logic        busSelect;
  logic        txd;
  logic        txIrq;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  logic wave[$];

  uart_tx_mmio dut (
    .clk            (clk),
    .reset          (reset),
    .busAddress     (busAddress),
    .busWriteData   (busWriteData),
    .busWriteEnable (busWriteEnable),
    .busReadData    (busReadData),
    .busSelect      (busSelect),
    .txd            (txd),
    .txIrq          (txIrq)
  );

  always #5 clk = ~clk;

  // wave[k-1] holds txd as it stands after clock edge k.
  always @(posedge clk) begin
    edge_cnt++;
    #2;
    wave.push_back(txd);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int e);
    busAddress     = a;
    busWriteData   = d;
    busWriteEnable = 1'b1;
    @(posedge clk);
    #1;
    busWriteEnable = 1'b0;
    e = edge_cnt;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    busWriteEnable = 1'b0;
    busAddress     = a;
    #1;
    d = busReadData;
  endtask

  task automatic wait_wave(input int n);
    int g = 0;
    while (wave.size() < n && g < 20000) begin
      @(posedge clk);
      #3;
      g++;
    end
    if (wave.size() < n) check_eq("wait_timeout", wave.size(), n);
  endtask

  // Ideal line level t cycles after the first start bit of a gap-free burst.
  function automatic logic model_txd(input logic [7:0] bytes[$], input int div, input int t);
    int fl = 10 * div;
    int f, b;
    if (t < 0) return 1'b1;
    f = t / fl;
    if (f >= bytes.size()) return 1'b1;
    b = (t % fl) / div;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return bytes[f][b-1];
  endfunction

  // ew is the TXDATA write edge; the first start bit begins on the next edge.
  task automatic check_frames(input string tag, input logic [7:0] bytes[$], input int div,
                              input int ew, input int extra);
    int fl = 10 * div;
    int n  = bytes.size() * fl + extra;
    int mism;
    logic [7:0] dec;
    wait_wave(ew + n);
    check_eq({tag, "_pre"}, 32'(wave[ew-1]), 32'd1);
    for (int f = 0; f < bytes.size(); f++) begin
      mism = 0;
      for (int t = f * fl; t < (f + 1) * fl; t++)
        if (wave[ew+t] !== model_txd(bytes, div, t)) mism++;
      for (int b = 0; b < 8; b++)
        dec[b] = wave[ew + f*fl + (b+1)*div + div/2];
      check_eq({tag, "_byte"}, 32'(dec), 32'(bytes[f]));
      check_eq({tag, "_timing"}, mism, 0);
    end
    mism = 0;
    for (int t = bytes.size() * fl; t < n; t++)
      if (wave[ew+t] !== 1'b1) mism++;
    check_eq({tag, "_idle"}, mism, 0);
  endtask

  initial begin
    logic [31:0] st;
    logic [7:0]  q[$];
    logic [7:0]  b;
    int          e, ew, ew1, er, div, div_w, n, mism;

    reset          = 1'b1;
    busAddress     = 32'd0;
    busWriteData   = 32'd0;
    busWriteEnable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    bus_read(A_ST, st);
    check_eq("rst_status", st, 32'h2);
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_irq", 32'(txIrq), 32'd1);
    check_eq("rst_select", 32'(busSelect), 32'd1);
    bus_read(A_DIV, st);
    check_eq("rst_divisor", st, 32'd434);

    // Single frame, DIVISOR=4
    bus_write(A_DIV, 32'd4, e);
    q.delete();
    q.push_back(8'h55);
    bus_write(A_TX, 32'h55, ew);
    wait_wave(ew + 40);
    bus_read(A_ST, st);
    check_eq("t2_busy_last", 32'(st[2]), 32'd1);
    wait_wave(ew + 41);
    bus_read(A_ST, st);
    check_eq("t2_busy_done", st, 32'h2);
    check_frames("t2", q, 4, ew, 4);

    // Two back-to-back writes give gap-free frames
    q.delete();
    q.push_back(8'hA5);
    q.push_back(8'h3C);
    bus_write(A_TX, 32'hA5, ew1);
    bus_read(A_ST, st);
    check_eq("t3_count1", 32'(st[12:8]), 32'd1);
    bus_write(A_TX, 32'h3C, e);
    bus_read(A_ST, st);
    check_eq("t3_count_pushpop", 32'(st[12:8]), 32'd1);
    wait_wave(ew1 + 45);
    bus_read(A_ST, st);
    check_eq("t3_count0", 32'(st[12:8]), 32'd0);
    check_eq("t3_busy", 32'(st[2]), 32'd1);
    check_frames("t3", q, 4, ew1, 6);

    // Overflow while busy
    bus_write(A_DIV, 32'd2, e);
    q.delete();
    b = 8'($urandom);
    q.push_back(b);
    bus_write(A_TX, 32'(b), ew);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      bus_write(A_TX, 32'(b), e);
      if (i < 16) q.push_back(b);
    end
    bus_read(A_ST, st);
    check_eq("t4_full_ovf", st, 32'h100D);
    bus_write(A_ST, 32'h8, e);
    bus_read(A_ST, st);
    check_eq("t4_ovf_clear", st, 32'h1005);
    check_frames("t4", q, 2, ew, 4);
    bus_read(A_ST, st);
    check_eq("t4_drained", st, 32'h2);

    // Reset in the middle of data bit 3
    bus_write(A_DIV, 32'd4, e);
    b = 8'($urandom) & 8'hF7;
    bus_write(A_TX, 32'(b), ew);
    bus_write(A_TX, 32'($urandom), e);
    bus_write(A_TX, 32'($urandom), e);
    wait_wave(ew + 18);
    check_eq("t5_bit3_low", 32'(txd), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("t5_async_txd", 32'(txd), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    er = edge_cnt;
    bus_read(A_ST, st);
    check_eq("t5_status", st, 32'h2);
    check_eq("t5_irq", 32'(txIrq), 32'd1);
    wait_wave(er + 60);
    mism = 0;
    for (int t = er - 1; t < er + 60; t++)
      if (wave[t] !== 1'b1) mism++;
    check_eq("t5_no_residue", mism, 0);

    // Window decode and divisor clamp
    bus_read(32'h8000_0010, st);
    check_eq("t6_sel_out", 32'(busSelect), 32'd0);
    check_eq("t6_rd_out", st, 32'd0);
    bus_write(32'h8000_0010, 32'hAB, e);
    bus_read(A_ST, st);
    check_eq("t6_wr_out_ignored", st, 32'h2);
    bus_read(A_RSV, st);
    check_eq("t6_rsv", st, 32'd0);
    bus_read(A_TX, st);
    check_eq("t6_txdata_rd", st, 32'd0);
    bus_write(A_DIV, 32'd0, e);
    bus_read(A_DIV, st);
    check_eq("t6_div_clamp", st, 32'd1);
    q.delete();
    b = 8'($urandom);
    q.push_back(b);
    bus_write(A_TX, 32'(b), ew);
    check_frames("t6", q, 1, ew, 3);

    // Randomised bursts with random divisors
    for (int it = 0; it < 8; it++) begin
      div_w = $urandom_range(0, 6);
      div   = (div_w == 0) ? 1 : div_w;
      bus_write(A_DIV, {16'($urandom), 16'(div_w)}, e);
      bus_read(A_DIV, st);
      check_eq("rnd_div", st, 32'(div));
      n = $urandom_range(1, 5);
      q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        q.push_back(b);
        if (k == 0) bus_write(A_TX, 32'(b), ew);
        else        bus_write(A_TX, 32'(b), e);
      end
      check_frames("rnd", q, div, ew, 5);
      bus_read(A_ST, st);
      check_eq("rnd_status", st, 32'h2);
      check_eq("rnd_irq", 32'(txIrq), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
